pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder_pkg.sv | 26 ++
 rtl/pe_feeder_addr_gen.sv | 56 +++++
 rtl/pe_feeder.sv | 157 +++++++++++++++
 tb/tb_pe_feeder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_feeder_pkg
//  Brief    : Shared FSM state encoding, PE control codes and result width.
//  Revision : 1.0
// ============================================================================
package pe_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] CTL_FIRST = 2'b01;
   localparam logic [1:0] CTL_LAST  = 2'b10;
   localparam int         RESULT_W  = 32;

   function automatic logic [1:0] ctl_code(input logic first, input logic last);
      return (first ? CTL_FIRST : 2'b00) | (last ? CTL_LAST : 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pe_feeder_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pe_feeder_addr_gen
//  Brief    : Walks both buffers element by element, flagging first/last.
//  Revision : 1.0
// ============================================================================
module pe_feeder_addr_gen
   import pe_feeder_pkg::*;
#(
   parameter int ADDR_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] len,
   input  logic [ADDR_W-1:0] n_base,
   input  logic [ADDR_W-1:0] w_base,
   output logic              rd_en,
   output logic [ADDR_W-1:0] n_addr,
   output logic [ADDR_W-1:0] w_addr,
   output logic              first,
   output logic              last
);

   // elements still to be issued, counting the one on the bus now
   logic [ADDR_W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en     <= 1'b0;
         n_addr    <= '0;
         w_addr    <= '0;
         remaining <= '0;
         first     <= 1'b0;
      end else if (load) begin
         rd_en     <= 1'b1;
         n_addr    <= n_base;
         w_addr    <= w_base;
         remaining <= len;
         first     <= 1'b1;
      end else if (rd_en) begin
         first     <= 1'b0;
         remaining <= remaining - 1'b1;
         if (remaining == ADDR_W'(1)) begin
            rd_en <= 1'b0;
         end else begin
            n_addr <= n_addr + 1'b1;
            w_addr <= w_addr + 1'b1;
         end
      end
   end

   assign last = rd_en && (remaining == ADDR_W'(1));

endmodule
`default_nettype wire

// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : pe_feeder
//  Brief    : Streams neuron/weight pairs to a serial PE and captures its
//             dot-product result. Optional WAIT timeout: PE_FEEDER_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
module pe_feeder
   import pe_feeder_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    len,
   input  logic [ADDR_W-1:0]    n_base,
   input  logic [ADDR_W-1:0]    w_base,
   output logic                 busy,
   output logic                 done,
   output logic [RESULT_W-1:0]  result_o,
   output logic                 err,
   output logic                 n_rd_en,
   output logic [ADDR_W-1:0]    n_addr,
   input  logic [15:0]          n_rd_data,
   output logic                 w_rd_en,
   output logic [ADDR_W-1:0]    w_addr,
   input  logic [15:0]          w_rd_data,
   output logic signed [15:0]   pe_neuron,
   output logic signed [15:0]   pe_weight,
   output logic [1:0]           pe_ctl,
   output logic                 pe_vld,
   input  logic [RESULT_W-1:0]  pe_result,
   input  logic                 pe_vld_i
);

   state_t state;
   logic   load;
   logic   ag_rd_en;
   logic   ag_first;
   logic   ag_last;

   assign load = (state == ST_IDLE) && start && (len != '0);

   pe_feeder_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .len    (len),
      .n_base (n_base),
      .w_base (w_base),
      .rd_en  (ag_rd_en),
      .n_addr (n_addr),
      .w_addr (w_addr),
      .first  (ag_first),
      .last   (ag_last)
   );

   assign n_rd_en = ag_rd_en;
   assign w_rd_en = ag_rd_en;

   // read data arrives one cycle after the address, so control follows by one
   always_ff @(posedge clk) begin
      if (rst) begin
         pe_vld <= 1'b0;
         pe_ctl <= 2'b00;
      end else begin
         pe_vld <= ag_rd_en;
         pe_ctl <= ag_rd_en ? ctl_code(ag_first, ag_last) : 2'b00;
      end
   end

   assign pe_neuron = pe_vld ? signed'(n_rd_data) : 16'sd0;
   assign pe_weight = pe_vld ? signed'(w_rd_data) : 16'sd0;

`ifdef PE_FEEDER_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0] wait_cnt;
`else
   // without the timeout the error flag can never be raised
   assign err = (TIMEOUT < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result_o <= '0;
`ifdef PE_FEEDER_TIMEOUT_EN
         err      <= 1'b0;
         wait_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
`ifdef PE_FEEDER_TIMEOUT_EN
                  err <= 1'b0;
`endif
                  if (len == '0) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     result_o <= '0;
                  end else begin
                     state <= ST_FETCH;
                     busy  <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (ag_last) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               state <= ST_WAIT;
`ifdef PE_FEEDER_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ST_WAIT: begin
               if (pe_vld_i) begin
                  result_o <= pe_result;
                  state    <= ST_DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
`ifdef PE_FEEDER_TIMEOUT_EN
               else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                  result_o <= '0;
                  err      <= 1'b1;
                  state    <= ST_DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_feeder
//  Brief    : Self-checking bench for pe_feeder with buffer and serial-PE models.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pe_feeder;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [ADDR_W-1:0]   len;
   logic [ADDR_W-1:0]   n_base;
   logic [ADDR_W-1:0]   w_base;
   logic                busy;
   logic                done;
   logic [31:0]         result_o;
   logic                err;
   logic                n_rd_en;
   logic [ADDR_W-1:0]   n_addr;
   logic [15:0]         n_rd_data;
   logic                w_rd_en;
   logic [ADDR_W-1:0]   w_addr;
   logic [15:0]         w_rd_data;
   logic signed [15:0]  pe_neuron;
   logic signed [15:0]  pe_weight;
   logic [1:0]          pe_ctl;
   logic                pe_vld;
   logic [31:0]         pe_result;
   logic                pe_vld_i;

   logic [15:0]         nmem [256];
   logic [15:0]         wmem [256];
   logic                pe_silent;
   logic signed [31:0]  acc;
   logic signed [31:0]  acc_next;
   logic signed [31:0]  prod;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pe_feeder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .n_base    (n_base),
      .w_base    (w_base),
      .busy      (busy),
      .done      (done),
      .result_o  (result_o),
      .err       (err),
      .n_rd_en   (n_rd_en),
      .n_addr    (n_addr),
      .n_rd_data (n_rd_data),
      .w_rd_en   (w_rd_en),
      .w_addr    (w_addr),
      .w_rd_data (w_rd_data),
      .pe_neuron (pe_neuron),
      .pe_weight (pe_weight),
      .pe_ctl    (pe_ctl),
      .pe_vld    (pe_vld),
      .pe_result (pe_result),
      .pe_vld_i  (pe_vld_i)
   );

   // buffers with one-cycle read latency
   always @(posedge clk) begin
      if (n_rd_en) n_rd_data <= nmem[n_addr];
      if (w_rd_en) w_rd_data <= wmem[w_addr];
   end

   // serial PE: restart on ctl[0], report sum the cycle after ctl[1]
   assign prod     = pe_neuron * pe_weight;
   assign acc_next = (pe_ctl[0] ? 32'sd0 : acc) + prod;

   always @(posedge clk) begin
      if (rst) begin
         acc       <= 32'sd0;
         pe_vld_i  <= 1'b0;
         pe_result <= 32'd0;
      end else begin
         pe_vld_i <= 1'b0;
         if (pe_vld) begin
            acc <= acc_next;
            if (pe_ctl[1] && !pe_silent) begin
               pe_result <= acc_next;
               pe_vld_i  <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {n_rd_en, w_rd_en, n_addr, w_addr, pe_vld, pe_ctl, neuron, weight, busy, done, err}
   function automatic logic [63:0] observe();
      return {8'h00, n_rd_en, w_rd_en,
              n_rd_en ? n_addr : 8'h00, w_rd_en ? w_addr : 8'h00,
              pe_vld, pe_ctl,
              pe_vld ? pe_neuron : 16'sd0, pe_vld ? pe_weight : 16'sd0,
              busy, done, err};
   endfunction

   function automatic logic [63:0] expect_at(input int k, input int jl,
                                             input logic [7:0] nb, input logic [7:0] wb);
      logic        rd, vld, bsy, dn;
      logic [1:0]  ctl;
      logic [7:0]  na, wa, ni, wi;
      logic [15:0] nv, wv;
      rd  = (jl > 0) && (k >= 1) && (k <= jl);
      vld = (jl > 0) && (k >= 2) && (k <= jl + 1);
      na  = rd ? nb + 8'(k - 1) : 8'h00;
      wa  = rd ? wb + 8'(k - 1) : 8'h00;
      ni  = nb + 8'(k - 2);
      wi  = wb + 8'(k - 2);
      nv  = vld ? nmem[ni] : 16'h0000;
      wv  = vld ? wmem[wi] : 16'h0000;
      ctl = vld ? {(k - 2 == jl - 1), (k == 2)} : 2'b00;
      bsy = (jl > 0) && (k >= 1) && (k <= jl + 2);
      dn  = (jl == 0) ? (k == 1) : (k == jl + 3);
      return {8'h00, rd, rd, na, wa, vld, ctl, nv, wv, bsy, dn, 1'b0};
   endfunction

   // one full job; expected result from the table when given, else from the buffers
   task automatic run_job(input int jl, input logic [7:0] nb, input logic [7:0] wb,
                          input bit restart, input bit use_exp, input logic [31:0] exp_res,
                          input string tag);
      int         sum;
      logic [7:0] a, b;
      sum = 0;
      for (int i = 0; i < jl; i++) begin
         a   = nb + 8'(i);
         b   = wb + 8'(i);
         sum = sum + $signed(nmem[a]) * $signed(wmem[b]);
      end
      if (use_exp) sum = exp_res;
      start  = 1'b1;
      len    = 8'(jl);
      n_base = nb;
      w_base = wb;
      for (int k = 1; k <= jl + 4; k++) begin
         @(negedge clk);
         check($sformatf("%s cyc%0d", tag, k), observe(), expect_at(k, jl, nb, wb));
         start = (k == 1) && restart;
         if (start) begin
            len    = 8'd3;
            n_base = ~nb;
            w_base = ~wb;
         end
      end
      check({tag, " result"}, {32'd0, result_o}, {32'd0, sum});
   endtask

   typedef struct {
      int          jl;
      logic [7:0]  nb;
      logic [7:0]  wb;
      logic [15:0] n [4];
      logic [15:0] w [4];
      bit          restart;
      logic [31:0] res;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int jl;
      logic [7:0] nb, wb, a;

      tbl[0].jl = 4; tbl[0].nb = 8'h10; tbl[0].wb = 8'h40; tbl[0].restart = 0; tbl[0].res = 32'd70;
      tbl[0].n = '{16'd1, 16'd2, 16'd3, 16'd4};
      tbl[0].w = '{16'd5, 16'd6, 16'd7, 16'd8};
      tbl[1].jl = 1; tbl[1].nb = 8'h20; tbl[1].wb = 8'h21; tbl[1].restart = 0; tbl[1].res = 32'hFFFFFFEB;
      tbl[1].n = '{16'hFFFD, 16'd0, 16'd0, 16'd0};
      tbl[1].w = '{16'd7, 16'd0, 16'd0, 16'd0};
      tbl[2].jl = 4; tbl[2].nb = 8'h30; tbl[2].wb = 8'h60; tbl[2].restart = 1; tbl[2].res = 32'd12;
      tbl[2].n = '{16'd10, 16'hFFFE, 16'd3, 16'd1};
      tbl[2].w = '{16'd1, 16'd1, 16'd1, 16'd1};
      tbl[3].jl = 0; tbl[3].nb = 8'h00; tbl[3].wb = 8'h00; tbl[3].restart = 0; tbl[3].res = 32'd0;
      tbl[3].n = '{16'd9, 16'd9, 16'd9, 16'd9};
      tbl[3].w = '{16'd9, 16'd9, 16'd9, 16'd9};
      tbl[4].jl = 4; tbl[4].nb = 8'hFE; tbl[4].wb = 8'h70; tbl[4].restart = 0; tbl[4].res = 32'd1111;
      tbl[4].n = '{16'd1, 16'd10, 16'd100, 16'd1000};
      tbl[4].w = '{16'd1, 16'd1, 16'd1, 16'd1};

      for (int i = 0; i < 256; i++) begin
         nmem[i] = 16'($urandom);
         wmem[i] = 16'($urandom);
      end
      rst = 1'b1; start = 1'b0; len = '0; n_base = '0; w_base = '0; pe_silent = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs", observe(), 64'd0);
      check("reset result", {32'd0, result_o}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 4; i++) begin
            a = tbl[v].nb + 8'(i); nmem[a] = tbl[v].n[i];
            a = tbl[v].wb + 8'(i); wmem[a] = tbl[v].w[i];
         end
         run_job(tbl[v].jl, tbl[v].nb, tbl[v].wb, tbl[v].restart, 1'b1, tbl[v].res,
                 $sformatf("vec%0d", v));
      end

      // reset in the middle of a len=8 job
      start = 1'b1; len = 8'd8; n_base = 8'h80; w_base = 8'h90;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort outputs", observe(), 64'd0);
      check("abort result", {32'd0, result_o}, 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check($sformatf("abort quiet%0d", k), observe(), 64'd0);
      end
      run_job(2, 8'h50, 8'hA0, 1'b0, 1'b0, 32'd0, "post_abort");

      // silent PE
      pe_silent = 1'b1;
      start = 1'b1; len = 8'd3; n_base = 8'h05; w_base = 8'h06;
      for (int k = 1; k <= 3 + 2 + TIMEOUT + 3; k++) begin
         @(negedge clk);
         start = 1'b0;
`ifdef PE_FEEDER_TIMEOUT_EN
         check($sformatf("timeout cyc%0d", k), {61'd0, busy, done, err},
               {61'd0, (k <= 3 + 2 + TIMEOUT - 1), (k == 3 + 2 + TIMEOUT), (k >= 3 + 2 + TIMEOUT)});
`else
         check($sformatf("silent cyc%0d", k), {61'd0, busy, done, err}, {61'd0, 1'b1, 1'b0, 1'b0});
`endif
      end
`ifdef PE_FEEDER_TIMEOUT_EN
      check("timeout result", {32'd0, result_o}, 64'd0);
`else
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`endif
      pe_silent = 1'b0;

      for (int r = 0; r < 25; r++) begin
         jl = int'($urandom_range(0, 12));
         nb = 8'($urandom);
         wb = 8'($urandom);
         for (int i = 0; i < 256; i++) begin
            nmem[i] = 16'($urandom);
            wmem[i] = 16'($urandom);
         end
         run_job(jl, nb, wb, (jl > 1) && ($urandom_range(0, 1) == 1), 1'b0, 32'd0,
                 $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
